// File: rtl/video_in_frame_writer.sv
// Video-in frame writer: streams 32-bit FIFO words into a frame buffer via locked
// Wishbone write bursts. Optional macro VIDEO_IN_DOUBLE_BUF_EN accepts addresses in any state.
module video_in_frame_writer #(
    parameter int unsigned P_WIDTH      = 640,
    parameter int unsigned P_HEIGHT     = 480,
    parameter int unsigned P_BURST      = 16,
    parameter int unsigned P_IRQ_CYCLES = 3
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] addr_data,
    input  logic        addr_valid,
    input  logic [31:0] fifo_data,
    input  logic        pack_available,
    output logic        fifo_rd,
    output logic        interrupt,
    output logic        err,
    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);
    localparam logic [31:0]    FRAME_WORDS = 32'(P_WIDTH * P_HEIGHT / 4);
    localparam int unsigned    BCW         = $clog2(P_BURST + 1);
    localparam int unsigned    ICW         = $clog2(P_IRQ_CYCLES + 1);
    localparam logic [BCW-1:0] BURST_LAST  = BCW'(P_BURST - 1);
    localparam logic [ICW-1:0] IRQ_LEN     = ICW'(P_IRQ_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_PACK, BURST} state_t;

    state_t          state;
    logic            wb_act;
    logic            pend_valid;
    logic [31:0]     pend_addr;
    logic [31:0]     base;
    logic [31:0]     word_offset;
    logic [BCW-1:0]  burst_cnt;
    logic [ICW-1:0]  irq_cnt;

    logic            addr_accept;
    logic            ack_ok;
    logic            bus_err;
    logic            frame_done;

`ifdef VIDEO_IN_DOUBLE_BUF_EN
    assign addr_accept = addr_valid;
`else
    assign addr_accept = addr_valid && (state == IDLE);
`endif

    // ERR wins over a simultaneous ACK, so such a beat never pops the FIFO.
    assign ack_ok     = wb_act & p_wb_ACK_I & ~p_wb_ERR_I;
    assign bus_err    = wb_act & p_wb_ERR_I;
    assign frame_done = ack_ok && (word_offset == FRAME_WORDS - 32'd1);

    assign fifo_rd     = ack_ok;
    assign interrupt   = (irq_cnt != '0);
    assign p_wb_CYC_O  = wb_act;
    assign p_wb_STB_O  = wb_act;
    assign p_wb_LOCK_O = wb_act;
    assign p_wb_WE_O   = wb_act;
    assign p_wb_SEL_O  = 4'hF;
    assign p_wb_ADR_O  = base + {word_offset[29:0], 2'b00};
    assign p_wb_DAT_O  = fifo_data;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            wb_act      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_addr   <= 32'd0;
            base        <= 32'd0;
            word_offset <= 32'd0;
            burst_cnt   <= '0;
            irq_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            if (state == IDLE && pend_valid) begin
                pend_valid <= 1'b0;
            end
            // A new strobe overrides the consume above so it is never lost.
            if (addr_accept) begin
                pend_valid <= 1'b1;
                pend_addr  <= addr_data;
                err        <= 1'b0;
            end

            if (frame_done) begin
                irq_cnt <= IRQ_LEN;
            end else if (irq_cnt != '0) begin
                irq_cnt <= irq_cnt - ICW'(1);
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        state       <= WAIT_PACK;
                        base        <= pend_addr;
                        word_offset <= 32'd0;
                    end
                end
                WAIT_PACK: begin
                    if (pack_available) begin
                        state     <= BURST;
                        wb_act    <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (bus_err) begin
                        state  <= IDLE;
                        wb_act <= 1'b0;
                        err    <= 1'b1;
                    end else if (ack_ok) begin
                        word_offset <= word_offset + 32'd1;
                        burst_cnt   <= burst_cnt + BCW'(1);
                        if (frame_done) begin
                            state  <= IDLE;
                            wb_act <= 1'b0;
                        end else if (burst_cnt == BURST_LAST) begin
                            state  <= WAIT_PACK;
                            wb_act <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    wb_act <= 1'b0;
                end
            endcase
        end
    end

endmodule
